display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed display scanner that sits directly upstream of the binary-to-seven-segment decoder. It accepts a packed multi-digit hex value through a valid/ready handshake and holds it in a shadow register. It cycles through the digits, presenting one 4-bit nibble per scan slot to the decoder along with a one-hot digit select. New values are swapped in only at frame boundaries, so the display never shows a mix of old and new digits.

Parameters:
NUM_DIGITS, 4, number of display digits scanned (>=2)
PRESCALE, 4, clock cycles each digit stays selected (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
in_val  input  1  in_data valid
in_rdy  output  1  block can accept in_data this cycle
in_data  input  4*NUM_DIGITS  packed value; nibble i = digit i, digit 0 least significant
blank_lz  input  1  enable leading-zero blanking (sampled combinationally)
digit_bin  output  4  nibble of the selected digit; feeds the seven-segment decoder input
digit_sel  output  NUM_DIGITS  one-hot, active-high select of the current digit
digit_blank  output  1  current digit must be blanked
frame_done  output  1  high during the last cycle of each full scan frame

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All registers update on the rising edge of clk.
- State: disp (4*NUM_DIGITS), pend (4*NUM_DIGITS), pend_valid, idx (clog2 NUM_DIGITS), cnt (clog2 PRESCALE, minimum 1 bit).
- Reset (rst_n=0 at an edge) sets:
  - disp=0, pend=0, pend_valid=0, idx=0, cnt=0.
  - While rst_n=0: in_rdy=0 and frame_done=0.
  - After release: digit_sel=0...01, digit_bin=0, digit_blank=0, in_rdy=1.
- Reset in mid-frame or with a pending value discards pend. The display restarts at digit 0.
- Handshake:
  - in_rdy = rst_n & !pend_valid.
  - Transfer occurs when in_val & in_rdy at an edge: pend <= in_data, pend_valid <= 1.
  - in_data need not be held after the transfer.
- Scan counter:
  - tick = (cnt == PRESCALE-1).
  - On tick: cnt <= 0 and idx advances, wrapping NUM_DIGITS-1 -> 0.
  - Otherwise cnt increments.
  - With PRESCALE=1, tick is constant 1 and idx advances every cycle.
- frame_done = tick & (idx == NUM_DIGITS-1). It is combinational (Moore on state).
- Frame swap: at an edge with frame_done=1 and pend_valid=1: disp <= pend, pend_valid <= 0.
- Simultaneous transfer and frame_done with pend_valid=0: the value goes into pend only. It is applied at the next frame boundary, never the same one.
- Outputs are combinational from registers only, with zero latency from idx:
  - digit_bin = disp nibble idx.
  - digit_sel = 1 << idx.
- Leading-zero blanking: digit_blank = blank_lz & (idx != 0) & (disp nibbles idx..NUM_DIGITS-1 all zero).
  - Digit 0 is never blanked, so 0 shows as a single "0".
- Latency: an accepted value becomes visible at the first frame boundary strictly after acceptance, at most NUM_DIGITS*PRESCALE+1 cycles later.

Decomposition:
- Shared constants header: default NUM_DIGITS and PRESCALE, and the nibble width (4).
- One natural sub-module, display_scan_tick: a parameterised prescaler plus digit-index counter with outputs idx, tick and frame_done.
- The handshake, pend/disp registers and blank logic stay in the top module.

Test Plan (NUM_DIGITS=4, PRESCALE=2 unless stated):
1. rst_n low 2 cycles, then release -> digit_sel=0001, digit_bin=0, digit_blank=0, in_rdy=1. frame_done first pulses 8 cycles after release.
2. Load 0x1234 one cycle after reset -> in_rdy=0 next cycle. Display stays 0 through the first frame_done edge. Then digit_bin sequence is 4,4,3,3,2,2,1,1 with digit_sel 0001,0001,0010,0010,0100,0100,1000,1000. in_rdy returns to 1.
3. Backpressure: present 0xAAAA while 0x5555 is pending -> in_rdy=0, in_val held. 0xAAAA transfers the cycle after the boundary that applies 0x5555, and appears one frame later.
4. blank_lz=1:
   - disp=0x0040 -> digits 3 and 2 blanked; digit 1 shows 4 and digit 0 shows 0, both unblanked.
   - disp=0x0000 -> only digit 0 unblanked.
   - blank_lz=0 -> no digit blanked.
5. Transfer of 0x00FF in the cycle where frame_done=1 -> not applied at that edge. Applied at the following frame_done edge.
6. Assert rst_n=0 mid-frame with pend_valid=1 -> next cycle disp=0, pend_valid=0, idx=0, cnt=0. Also run with PRESCALE=1: idx advances every cycle and frame_done is high every 4th cycle.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Purpose: shared constants and sizing helpers for the display scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_scan_ctrl_pkg;

   localparam int NIBBLE_W       = 4;   // one hex digit per scan slot
   localparam int DEF_NUM_DIGITS = 4;
   localparam int DEF_PRESCALE   = 4;

   // Prescale counter width; PRESCALE of 1 still keeps a 1-bit counter so the
   // register never collapses to zero width.
   function automatic int cnt_width(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Purpose: value-load handshake plus scan outputs of the display scanner.
// Latency: n/a (wiring only).
// Backpressure: in_rdy low while a value is already waiting for a frame boundary.
// Signals: in_val/in_rdy/in_data load handshake, blank_lz blanking enable,
//          digit_bin/digit_sel/digit_blank per-slot outputs, frame_done frame marker.
interface display_scan_ctrl_if #(
   parameter int NUM_DIGITS = display_scan_ctrl_pkg::DEF_NUM_DIGITS
);
   import display_scan_ctrl_pkg::*;

   logic                           in_val;
   logic                           in_rdy;
   logic [NIBBLE_W*NUM_DIGITS-1:0] in_data;
   logic                           blank_lz;
   logic [NIBBLE_W-1:0]            digit_bin;
   logic [NUM_DIGITS-1:0]          digit_sel;
   logic                           digit_blank;
   logic                           frame_done;

   // Producer / display-side view
   modport master (
      output in_val, in_data, blank_lz,
      input  in_rdy, digit_bin, digit_sel, digit_blank, frame_done
   );

   // Scanner view
   modport slave (
      input  in_val, in_data, blank_lz,
      output in_rdy, digit_bin, digit_sel, digit_blank, frame_done
   );

endinterface

// File: rtl/display_scan_tick.sv
// Purpose: prescaler plus digit-index counter that paces the display scan.
// Latency: outputs are combinational from the counter registers (zero cycles).
// Backpressure: none; free-running once out of reset.
// Ports: i_clk, i_rst_n (sync, active-low); o_idx current digit, o_tick last
//        cycle of a digit slot, o_frame_done last cycle of the last digit slot.
module display_scan_tick #(
   parameter  int NUM_DIGITS = display_scan_ctrl_pkg::DEF_NUM_DIGITS,
   parameter  int PRESCALE   = display_scan_ctrl_pkg::DEF_PRESCALE,
   localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_tick,
   output logic             o_frame_done
);
   import display_scan_ctrl_pkg::*;

   localparam int               CNT_W    = cnt_width(PRESCALE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic             w_tick;

   // With PRESCALE=1 CNT_LAST is 0 and the counter never leaves 0, so tick is
   // permanently high and the index steps every cycle.
   assign w_tick = (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
         // explicit wrap: NUM_DIGITS need not be a power of two
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_idx        = r_idx;
   assign o_tick       = w_tick;
   // held low while in reset so the frame marker never fires on stale state
   assign o_frame_done = i_rst_n & w_tick & (r_idx == IDX_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Purpose: time-multiplexed hex display scanner feeding a seven-segment decoder.
// Latency: accepted value shows at the first frame boundary after acceptance.
// Backpressure: in_rdy drops while one value waits; it reopens after the swap.
// Ports: i_clk, i_rst_n (sync, active-low); io_bus carries the load handshake,
//        blank_lz, and the per-slot digit_bin/digit_sel/digit_blank/frame_done.
module display_scan_ctrl #(
   parameter int NUM_DIGITS = display_scan_ctrl_pkg::DEF_NUM_DIGITS,
   parameter int PRESCALE   = display_scan_ctrl_pkg::DEF_PRESCALE
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   display_scan_ctrl_if.slave  io_bus
);
   import display_scan_ctrl_pkg::*;

   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int DATA_W = NIBBLE_W * NUM_DIGITS;

   logic [DATA_W-1:0] r_disp;        // value currently being scanned out
   logic [DATA_W-1:0] r_pend;        // shadow value waiting for a frame boundary
   logic              r_pend_valid;

   logic [IDX_W-1:0]  w_idx;
   logic              w_tick;
   logic              w_frame_done;
   logic              w_in_rdy;
   logic              w_xfer;
   logic [DATA_W-1:0] w_disp_hi;     // disp shifted so the selected digit is nibble 0

   display_scan_tick #(
      .NUM_DIGITS (NUM_DIGITS),
      .PRESCALE   (PRESCALE)
   ) u_tick (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .o_idx        (w_idx),
      .o_tick       (w_tick),
      .o_frame_done (w_frame_done)
   );

   assign w_in_rdy = i_rst_n & ~r_pend_valid;
   assign w_xfer   = io_bus.in_val & w_in_rdy;

   // A transfer can only happen with r_pend_valid clear, so it never competes
   // with a swap; a value accepted on a frame_done edge lands in pend and waits
   // for the next boundary.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_disp       <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
      end else begin
         if (w_frame_done && r_pend_valid) begin
            r_disp       <= r_pend;
            r_pend_valid <= 1'b0;
         end
         if (w_xfer) begin
            r_pend       <= io_bus.in_data;
            r_pend_valid <= 1'b1;
         end
      end
   end

   assign w_disp_hi = r_disp >> (w_idx * NIBBLE_W);

   assign io_bus.in_rdy      = w_in_rdy;
   assign io_bus.frame_done  = w_frame_done;
   assign io_bus.digit_bin   = w_disp_hi[NIBBLE_W-1:0];
   assign io_bus.digit_sel   = NUM_DIGITS'(1) << w_idx;
   // After the shift only digits idx..NUM_DIGITS-1 remain, so a zero result
   // means every digit from here upward is zero. Digit 0 always shows.
   assign io_bus.digit_blank = io_bus.blank_lz & (w_idx != '0) & (w_disp_hi == '0);

   // The frame boundary is by construction the last slot tick.
   a_frame_on_tick : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                      w_frame_done |-> w_tick);

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

   localparam int N     = 4;
   localparam int P     = 2;
   localparam int FRAME = N * P;
   localparam int WBND  = 4 * FRAME;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   display_scan_ctrl_if #(.NUM_DIGITS(N)) bus  ();
   display_scan_ctrl_if #(.NUM_DIGITS(N)) bus1 ();

   display_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P)) u_dut (
      .i_clk (clk), .i_rst_n (rst_n), .io_bus (bus)
   );
   display_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(1)) u_dut_p1 (
      .i_clk (clk), .i_rst_n (rst_n), .io_bus (bus1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: cycles since reset release plus the two value slots.
   int          m_t;
   logic [15:0] m_disp, m_pend;
   bit          m_pv;

   function automatic int exp_idx(input int p);
      return (m_t / p) % N;
   endfunction

   function automatic logic [3:0] exp_bin();
      logic [15:0] s;
      s = m_disp >> (4 * exp_idx(P));
      return s[3:0];
   endfunction

   function automatic logic [N-1:0] exp_sel(input int p);
      logic [N-1:0] s;
      s = '0;
      s[exp_idx(p)] = 1'b1;
      return s;
   endfunction

   function automatic logic exp_blank();
      logic [15:0] s;
      s = m_disp >> (4 * exp_idx(P));
      return bus.blank_lz && (exp_idx(P) != 0) && (s == 16'h0);
   endfunction

   function automatic logic exp_fd(input int p);
      return rst_n && ((m_t % (N * p)) == (N * p - 1));
   endfunction

   // One clock edge; the model applies the rules using the inputs seen before it.
   task automatic step();
      bit rst_seen, fd, xfer;
      rst_seen = !rst_n;
      fd       = (m_t % FRAME) == FRAME - 1;
      xfer     = bus.in_val && !m_pv;
      @(posedge clk);
      #1;
      if (rst_seen) begin
         m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
      end else begin
         m_t++;
         if (fd && m_pv) begin m_disp = m_pend; m_pv = 1'b0; end
         if (xfer) begin m_pend = bus.in_data; m_pv = 1'b1; end
      end
   endtask

   // Stimulus only: load v and wait until it is being displayed (frame start).
   task automatic apply_value(input logic [15:0] v, output bit ok);
      int w;
      w = 0;
      bus.in_val = 1'b1; bus.in_data = v;
      #1;
      while (bus.in_rdy !== 1'b1 && w < WBND) begin step(); #1; w++; end
      step();
      bus.in_val = 1'b0;
      #1;
      while (bus.in_rdy !== 1'b1 && w < WBND) begin step(); #1; w++; end
      ok = (w < WBND);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; bus.in_val = 1'b0; bus.in_data = '0; bus.blank_lz = 1'b0;
      step();
      n_checks++; if (bus.in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 0", bus.in_rdy); end
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
      step();
      rst_n = 1'b1;
      #1;
      n_checks++; if (bus.digit_sel !== 4'b0001) begin n_fail++; $display("FAIL reset_sel: got %b want 0001", bus.digit_sel); end
      n_checks++; if (bus.digit_bin !== 4'h0) begin n_fail++; $display("FAIL reset_bin: got %h want 0", bus.digit_bin); end
      n_checks++; if (bus.digit_blank !== 1'b0) begin n_fail++; $display("FAIL reset_blank: got %b want 0", bus.digit_blank); end
      n_checks++; if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL release_in_rdy: got %b want 1", bus.in_rdy); end
      for (int c = 0; c < FRAME; c++) begin
         n_checks++; if (bus.frame_done !== (c == FRAME - 1)) begin n_fail++; $display("FAIL first_frame_done c=%0d: got %b want %b", c, bus.frame_done, (c == FRAME - 1)); end
         step();
      end
   endtask

   task automatic test_load();
      logic [3:0] eb [8] = '{4'h4, 4'h4, 4'h3, 4'h3, 4'h2, 4'h2, 4'h1, 4'h1};
      logic [3:0] es [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
      int w;
      rst_n = 1'b0; step(); step(); rst_n = 1'b1;
      step();
      bus.in_val = 1'b1; bus.in_data = 16'h1234;
      step();
      bus.in_val = 1'b0; bus.in_data = 16'($urandom);
      #1;
      n_checks++; if (bus.in_rdy !== 1'b0) begin n_fail++; $display("FAIL load_in_rdy: got %b want 0", bus.in_rdy); end
      w = 0;
      while (bus.frame_done !== 1'b1 && w < WBND) begin
         n_checks++; if (bus.digit_bin !== 4'h0) begin n_fail++; $display("FAIL load_early_bin: got %h want 0", bus.digit_bin); end
         step(); w++;
      end
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL load_frame_wait: got frame_done %b want 1 within %0d cycles", bus.frame_done, WBND); end
      n_checks++; if (bus.digit_bin !== 4'h0) begin n_fail++; $display("FAIL load_boundary_bin: got %h want 0", bus.digit_bin); end
      step();
      for (int c = 0; c < 8; c++) begin
         n_checks++; if (bus.digit_bin !== eb[c]) begin n_fail++; $display("FAIL load_seq_bin c=%0d: got %h want %h", c, bus.digit_bin, eb[c]); end
         n_checks++; if (bus.digit_sel !== es[c]) begin n_fail++; $display("FAIL load_seq_sel c=%0d: got %b want %b", c, bus.digit_sel, es[c]); end
         n_checks++; if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL load_rdy_back c=%0d: got %b want 1", c, bus.in_rdy); end
         step();
      end
   endtask

   task automatic test_backpressure();
      int w;
      bit prev_fd;
      bus.in_val = 1'b1; bus.in_data = 16'h5555;
      step();
      bus.in_data = 16'hAAAA;
      #1;
      n_checks++; if (bus.in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_rdy: got %b want 0", bus.in_rdy); end
      w = 0; prev_fd = 1'b0;
      while (bus.in_rdy !== 1'b1 && w < WBND) begin prev_fd = bus.frame_done; step(); w++; end
      n_checks++; if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release: got in_rdy %b want 1", bus.in_rdy); end
      n_checks++; if (prev_fd !== 1'b1) begin n_fail++; $display("FAIL bp_release_boundary: got prev frame_done %b want 1", prev_fd); end
      n_checks++; if (bus.digit_bin !== 4'h5) begin n_fail++; $display("FAIL bp_first_applied: got %h want 5", bus.digit_bin); end
      step();
      bus.in_val = 1'b0;
      #1;
      n_checks++; if (bus.in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_second_taken: got in_rdy %b want 0", bus.in_rdy); end
      w = 0;
      while (bus.frame_done !== 1'b1 && w < WBND) begin
         n_checks++; if (bus.digit_bin !== 4'h5) begin n_fail++; $display("FAIL bp_hold_bin: got %h want 5", bus.digit_bin); end
         step(); w++;
      end
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL bp_frame_wait: got %b want 1", bus.frame_done); end
      step();
      n_checks++; if (bus.digit_bin !== 4'hA) begin n_fail++; $display("FAIL bp_second_applied: got %h want a", bus.digit_bin); end
   endtask

   task automatic test_blank();
      bit ok;
      int idx;
      apply_value(16'h0040, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL blank_load_0040: got timeout want value applied"); end
      bus.blank_lz = 1'b1;
      #1;
      for (int c = 0; c < FRAME; c++) begin
         idx = c / P;
         n_checks++; if (bus.digit_blank !== (idx >= 2)) begin n_fail++; $display("FAIL blank_0040 idx=%0d: got %b want %b", idx, bus.digit_blank, (idx >= 2)); end
         n_checks++; if (bus.digit_bin !== ((idx == 1) ? 4'h4 : 4'h0)) begin n_fail++; $display("FAIL blank_0040_bin idx=%0d: got %h", idx, bus.digit_bin); end
         step();
      end
      apply_value(16'h0000, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL blank_load_0000: got timeout want value applied"); end
      for (int c = 0; c < FRAME; c++) begin
         idx = c / P;
         n_checks++; if (bus.digit_blank !== (idx != 0)) begin n_fail++; $display("FAIL blank_0000 idx=%0d: got %b want %b", idx, bus.digit_blank, (idx != 0)); end
         step();
      end
      bus.blank_lz = 1'b0;
      #1;
      for (int c = 0; c < FRAME; c++) begin
         n_checks++; if (bus.digit_blank !== 1'b0) begin n_fail++; $display("FAIL blank_off c=%0d: got %b want 0", c, bus.digit_blank); end
         step();
      end
   endtask

   task automatic test_frame_edge_xfer();
      logic [3:0] old_n [4] = '{4'h6, 4'h7, 4'h8, 4'h9};
      logic [3:0] new_n [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
      bit ok;
      apply_value(16'h9876, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL edge_load_9876: got timeout want value applied"); end
      for (int c = 0; c < FRAME - 1; c++) step();
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL edge_frame_done: got %b want 1", bus.frame_done); end
      n_checks++; if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL edge_in_rdy: got %b want 1", bus.in_rdy); end
      bus.in_val = 1'b1; bus.in_data = 16'h00FF;
      step();
      bus.in_val = 1'b0;
      #1;
      n_checks++; if (bus.in_rdy !== 1'b0) begin n_fail++; $display("FAIL edge_taken: got in_rdy %b want 0", bus.in_rdy); end
      for (int c = 0; c < FRAME; c++) begin
         n_checks++; if (bus.digit_bin !== old_n[c / P]) begin n_fail++; $display("FAIL edge_not_same_frame c=%0d: got %h want %h", c, bus.digit_bin, old_n[c / P]); end
         step();
      end
      for (int c = 0; c < FRAME; c++) begin
         n_checks++; if (bus.digit_bin !== new_n[c / P]) begin n_fail++; $display("FAIL edge_next_frame c=%0d: got %h want %h", c, bus.digit_bin, new_n[c / P]); end
         step();
      end
   endtask

   task automatic test_reset_midframe();
      logic [N-1:0] want_sel1;
      step(); step(); step();
      bus.in_val = 1'b1; bus.in_data = 16'h4321;
      step();
      bus.in_val = 1'b0;
      #1;
      n_checks++; if (bus.in_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_pending: got in_rdy %b want 0", bus.in_rdy); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.in_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_rdy: got %b want 0", bus.in_rdy); end
      step();
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_frame_done: got %b want 0", bus.frame_done); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (bus.digit_sel !== 4'b0001) begin n_fail++; $display("FAIL mid_sel: got %b want 0001", bus.digit_sel); end
      n_checks++; if (bus.in_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_in_rdy: got %b want 1", bus.in_rdy); end
      for (int c = 0; c < 3 * N; c++) begin
         want_sel1 = '0;
         want_sel1[c % N] = 1'b1;
         n_checks++; if (bus.digit_bin !== 4'h0) begin n_fail++; $display("FAIL mid_pend_dropped c=%0d: got %h want 0", c, bus.digit_bin); end
         n_checks++; if (bus.frame_done !== ((c % FRAME) == FRAME - 1)) begin n_fail++; $display("FAIL mid_frame_done c=%0d: got %b", c, bus.frame_done); end
         n_checks++; if (bus1.digit_sel !== want_sel1) begin n_fail++; $display("FAIL p1_sel c=%0d: got %b want %b", c, bus1.digit_sel, want_sel1); end
         n_checks++; if (bus1.frame_done !== ((c % N) == N - 1)) begin n_fail++; $display("FAIL p1_frame_done c=%0d: got %b want %b", c, bus1.frame_done, ((c % N) == N - 1)); end
         step();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_n         = ($urandom_range(0, 63) != 0);
         bus.in_val    = ($urandom_range(0, 2) == 0);
         bus.in_data   = 16'($urandom);
         bus.blank_lz  = $urandom_range(0, 1) == 1;
         #1;
         n_checks++; if (bus.in_rdy !== (rst_n && !m_pv)) begin n_fail++; $display("FAIL rnd_in_rdy i=%0d: got %b want %b", i, bus.in_rdy, (rst_n && !m_pv)); end
         n_checks++; if (bus.frame_done !== exp_fd(P)) begin n_fail++; $display("FAIL rnd_frame_done i=%0d: got %b want %b", i, bus.frame_done, exp_fd(P)); end
         n_checks++; if (bus.digit_sel !== exp_sel(P)) begin n_fail++; $display("FAIL rnd_sel i=%0d: got %b want %b", i, bus.digit_sel, exp_sel(P)); end
         n_checks++; if (bus.digit_bin !== exp_bin()) begin n_fail++; $display("FAIL rnd_bin i=%0d: got %h want %h", i, bus.digit_bin, exp_bin()); end
         n_checks++; if (bus.digit_blank !== exp_blank()) begin n_fail++; $display("FAIL rnd_blank i=%0d: got %b want %b", i, bus.digit_blank, exp_blank()); end
         n_checks++; if (bus1.digit_sel !== exp_sel(1)) begin n_fail++; $display("FAIL rnd_p1_sel i=%0d: got %b want %b", i, bus1.digit_sel, exp_sel(1)); end
         n_checks++; if (bus1.frame_done !== exp_fd(1)) begin n_fail++; $display("FAIL rnd_p1_frame_done i=%0d: got %b want %b", i, bus1.frame_done, exp_fd(1)); end
         step();
      end
      rst_n = 1'b1;
      bus.in_val = 1'b0;
   endtask

   initial begin
      m_t = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
      bus1.in_val = 1'b0; bus1.in_data = '0; bus1.blank_lz = 1'b0;
      test_reset();
      test_load();
      test_backpressure();
      test_blank();
      test_frame_edge_xfer();
      test_reset_midframe();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test want completion before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
